// File: rtl/copr_share_arbiter_pkg.sv
// Shared types for the coprocessor share arbiter: datapath width, ROB tag and requester ID.
package copr_share_arbiter_pkg;
  localparam int XLEN       = 32;
  localparam int ROB_IDX_W  = 6;
  localparam int COPR_N_REQ = 2;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [$clog2(COPR_N_REQ)-1:0] copr_req_id_t;

  // Width of a requester ID; a single requester still needs one bit to hold it.
  function automatic int id_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction
endpackage

// File: rtl/copr_id_fifo.sv
// Synchronous FIFO holding the requester ID of each op issued to the coprocessor, oldest first.
module copr_id_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register in this clocked block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone decide which
  // entries are valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/copr_share_arbiter.sv
// Shares one in-order coprocessor EU among N_REQ requesters: arbitrates issue, remembers the
// issuing requester per op, and steers each returning result back to that requester.
module copr_share_arbiter
  import copr_share_arbiter_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int MAX_INFLIGHT = 8,
  parameter int CTL_LEN      = 4,
  parameter bit RR_ARBITER   = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [N_REQ-1:0]             req_valid_i,
  output logic [N_REQ-1:0]             req_ready_o,
  input  logic [N_REQ*CTL_LEN-1:0]     req_ctl_i,
  input  logic [N_REQ*ROB_IDX_W-1:0]   req_tag_i,
  input  logic [N_REQ*XLEN-1:0]        req_rs1_i,
  input  logic [N_REQ*XLEN-1:0]        req_rs2_i,
  output logic                         copr_valid_o,
  input  logic                         copr_ready_i,
  output logic [CTL_LEN-1:0]           copr_ctl_o,
  output rob_idx_t                     copr_tag_o,
  output logic [XLEN-1:0]              copr_rs1_o,
  output logic [XLEN-1:0]              copr_rs2_o,
  input  logic                         copr_valid_i,
  output logic                         copr_ready_o,
  input  rob_idx_t                     copr_tag_i,
  input  logic [XLEN-1:0]              copr_result_i,
  output logic [N_REQ-1:0]             resp_valid_o,
  input  logic [N_REQ-1:0]             resp_ready_i,
  output rob_idx_t                     resp_tag_o,
  output logic [XLEN-1:0]              resp_result_o,
  output logic                         err_o
);
  localparam int ID_W = id_width(N_REQ);

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] grant, head_id;
  logic            err_q, err_set;
  logic            fifo_full, fifo_empty;
  logic            blocked, any_valid, issue_fire, pop;

  // Reset and flush both freeze the handshakes for the current cycle.
  assign blocked   = rst_i | flush_i;
  assign any_valid = |req_valid_i;

  // NOTE: every always_comb output gets a default before any branch, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin : arbitrate
    int idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (RR_ARBITER) begin
        idx = int'(rr_ptr_q) + i;
        if (idx >= N_REQ) idx = idx - N_REQ;
      end else begin
        idx = i;
      end
      if (!found && req_valid_i[idx]) begin
        grant = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign copr_valid_o = any_valid & ~fifo_full & ~blocked;
  assign issue_fire   = copr_valid_o & copr_ready_i;

  always_comb begin : issue_route
    req_ready_o        = '0;
    req_ready_o[grant] = issue_fire;
    copr_ctl_o         = req_ctl_i[grant*CTL_LEN +: CTL_LEN];
    copr_tag_o         = req_tag_i[grant*ROB_IDX_W +: ROB_IDX_W];
    copr_rs1_o         = req_rs1_i[grant*XLEN +: XLEN];
    copr_rs2_o         = req_rs2_i[grant*XLEN +: XLEN];
    rr_ptr_d           = rr_ptr_q;
    if (issue_fire) begin
      rr_ptr_d = (int'(grant) == N_REQ - 1) ? '0 : grant + ID_W'(1);
    end
  end

  // Results with nothing in flight are drained and flagged rather than stalling the EU.
  always_comb begin : result_route
    resp_valid_o = '0;
    copr_ready_o = 1'b1;
    pop          = 1'b0;
    err_set      = 1'b0;
    if (!blocked) begin
      if (fifo_empty) begin
        err_set = copr_valid_i;
      end else begin
        copr_ready_o          = resp_ready_i[head_id];
        resp_valid_o[head_id] = copr_valid_i;
        pop                   = copr_valid_i & resp_ready_i[head_id];
      end
    end
  end

  assign resp_tag_o    = copr_tag_i;
  assign resp_result_o = copr_result_i;
  assign err_o         = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_q | err_set;
    end
  end

  copr_id_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .W     (ID_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (issue_fire),
    .data_i  (grant),
    .pop_i   (pop),
    .data_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
endmodule

// File: tb/tb_copr_share_arbiter.sv
// Randomized bench for copr_share_arbiter, checked cycle by cycle against a queue-based model.
module tb_copr_share_arbiter;
  import copr_share_arbiter_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 8;
  localparam int CTL   = 4;
  localparam bit RR    = 1'b1;

  logic                  clk = 1'b0;
  logic                  rst_i, flush_i;
  logic [N-1:0]          req_valid_i, req_ready_o;
  logic [N*CTL-1:0]      req_ctl_i;
  logic [N*ROB_IDX_W-1:0] req_tag_i;
  logic [N*XLEN-1:0]     req_rs1_i, req_rs2_i;
  logic                  copr_valid_o, copr_ready_i;
  logic [CTL-1:0]        copr_ctl_o;
  rob_idx_t              copr_tag_o;
  logic [XLEN-1:0]       copr_rs1_o, copr_rs2_o;
  logic                  copr_valid_i, copr_ready_o;
  rob_idx_t              copr_tag_i;
  logic [XLEN-1:0]       copr_result_i;
  logic [N-1:0]          resp_valid_o, resp_ready_i;
  rob_idx_t              resp_tag_o;
  logic [XLEN-1:0]       resp_result_o;
  logic                  err_o;

  copr_share_arbiter #(
    .N_REQ(N), .MAX_INFLIGHT(DEPTH), .CTL_LEN(CTL), .RR_ARBITER(RR)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_ctl_i(req_ctl_i),
    .req_tag_i(req_tag_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
    .copr_valid_o(copr_valid_o), .copr_ready_i(copr_ready_i), .copr_ctl_o(copr_ctl_o),
    .copr_tag_o(copr_tag_o), .copr_rs1_o(copr_rs1_o), .copr_rs2_o(copr_rs2_o),
    .copr_valid_i(copr_valid_i), .copr_ready_o(copr_ready_o), .copr_tag_i(copr_tag_i),
    .copr_result_i(copr_result_i), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_tag_o(resp_tag_o), .resp_result_o(resp_result_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Reference model: owners of in-flight ops in issue order, round-robin start, sticky error.
  int owner_q[$];
  int rr_m     = 0;
  bit err_m    = 1'b0;
  bit model_ok = 1'b0;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input bit rst, input bit flush, input bit [N-1:0] rv,
                      input bit cr, input bit cv, input bit [N-1:0] rrdy);
    bit blocked, full, empty, exp_cv, fire, pop, exp_cready;
    bit [N-1:0] exp_rdy, exp_resp;
    int g, h, cand;
    @(negedge clk);
    rst_i = rst; flush_i = flush; req_valid_i = rv; copr_ready_i = cr;
    copr_valid_i = cv; resp_ready_i = rrdy;
    for (int i = 0; i < N; i++) begin
      req_ctl_i[i*CTL +: CTL]             = CTL'($urandom);
      req_tag_i[i*ROB_IDX_W +: ROB_IDX_W] = ROB_IDX_W'($urandom);
      req_rs1_i[i*XLEN +: XLEN]           = $urandom;
      req_rs2_i[i*XLEN +: XLEN]           = $urandom;
    end
    copr_tag_i    = ROB_IDX_W'($urandom);
    copr_result_i = $urandom;
    #1;
    blocked = rst || flush;
    full    = (owner_q.size() >= DEPTH);
    empty   = (owner_q.size() == 0);
    g = -1;
    for (int k = 0; k < N; k++) begin
      cand = RR ? (rr_m + k) % N : k;
      if (g < 0 && rv[cand]) g = cand;
    end
    exp_cv  = (g >= 0) && !full && !blocked;
    fire    = exp_cv && cr;
    exp_rdy = fire ? N'(1 << g) : '0;
    check("copr_valid", 128'(copr_valid_o), 128'(exp_cv));
    check("req_ready", 128'(req_ready_o), 128'(exp_rdy));
    if (exp_cv)
      check("issue_payload", 128'({copr_ctl_o, copr_tag_o, copr_rs1_o, copr_rs2_o}),
            128'({req_ctl_i[g*CTL +: CTL], req_tag_i[g*ROB_IDX_W +: ROB_IDX_W],
                  req_rs1_i[g*XLEN +: XLEN], req_rs2_i[g*XLEN +: XLEN]}));
    pop = 1'b0;
    exp_resp = '0;
    if (!blocked && model_ok) begin
      if (empty) begin
        exp_cready = 1'b1;
      end else begin
        h          = owner_q[0];
        exp_cready = rrdy[h];
        exp_resp   = cv ? N'(1 << h) : '0;
        pop        = cv && rrdy[h];
      end
      check("copr_ready", 128'(copr_ready_o), 128'(exp_cready));
    end
    if (blocked || model_ok) check("resp_valid", 128'(resp_valid_o), 128'(exp_resp));
    check("resp_passthru", 128'({resp_tag_o, resp_result_o}), 128'({copr_tag_i, copr_result_i}));
    if (model_ok) check("err", 128'(err_o), 128'(err_m));
    @(posedge clk);
    if (rst) begin
      owner_q.delete();
      rr_m = 0; err_m = 1'b0; model_ok = 1'b1;
    end else if (flush) begin
      owner_q.delete();
    end else begin
      if (pop) void'(owner_q.pop_front());
      if (fire) begin
        owner_q.push_back(g);
        rr_m = (g + 1) % N;
      end
      if (empty && cv) err_m = 1'b1;
    end
  endtask

  initial begin
    int p_cv, p_cr;
    bit r_rst, r_fl, r_cr, r_cv;
    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = '0; copr_ready_i = 1'b0;
    copr_valid_i = 1'b0; resp_ready_i = '0; req_ctl_i = '0; req_tag_i = '0;
    req_rs1_i = '0; req_rs2_i = '0; copr_tag_i = '0; copr_result_i = '0;

    // Reset held two cycles with every requester asking.
    repeat (2) step(1, 0, 2'b11, 1, 0, 2'b11);
    step(0, 0, 2'b00, 1, 0, 2'b11);
    // Round-robin alternation, then in-order routing of four results.
    repeat (4) step(0, 0, 2'b11, 1, 0, 2'b00);
    repeat (4) step(0, 0, 2'b00, 0, 1, 2'b11);
    // Result backpressure from the owning requester.
    step(0, 0, 2'b01, 1, 0, 2'b00);
    repeat (2) step(0, 0, 2'b00, 0, 1, 2'b10);
    step(0, 0, 2'b00, 0, 1, 2'b11);
    // Fill to MAX_INFLIGHT, then request while a pop happens in the same cycle.
    repeat (DEPTH) step(0, 0, 2'b11, 1, 0, 2'b00);
    step(0, 0, 2'b11, 1, 1, 2'b11);
    step(0, 0, 2'b11, 1, 1, 2'b11);
    // Flush with ops in flight, then a stray result on the empty FIFO.
    step(0, 1, 2'b11, 1, 1, 2'b11);
    step(0, 0, 2'b00, 1, 1, 2'b11);
    step(0, 0, 2'b00, 1, 0, 2'b11);
    step(1, 0, 2'b00, 0, 0, 2'b00);

    p_cv = 4; p_cr = 4;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        p_cv = $urandom_range(0, 8);
        p_cr = $urandom_range(1, 8);
      end
      r_rst = ($urandom_range(0, 399) == 0);
      r_fl  = ($urandom_range(0, 49) == 0);
      r_cr  = ($urandom_range(0, 7) < p_cr);
      r_cv  = ($urandom_range(0, 7) < p_cv);
      step(r_rst, r_fl, N'($urandom), r_cr, r_cv, N'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
